select_encode_regfile: RTL and testbench

SELECT_ENCODE_REGFILE -- requirements
Module: select_encode_regfile

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/decoder_4to16.sv | 16 +
 rtl/select_encode_regfile.sv | 125 ++++++++++++
 tb/tb_select_encode_regfile.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register count, constant width, IR field positions
// and the register-address type used by the select/encode logic.
package cpu_pkg;

   localparam int NREGS_DEF  = 16;
   localparam int CWIDTH_DEF = 19;

   localparam int OPCODE_MSB = 31;
   localparam int OPCODE_LSB = 27;
   localparam int RA_MSB     = 26;
   localparam int RA_LSB     = 23;
   localparam int RB_MSB     = 22;
   localparam int RB_LSB     = 19;
   localparam int RC_MSB     = 18;
   localparam int RC_LSB     = 15;
   localparam int C_MSB      = 18;
   localparam int C_LSB      = 0;

   typedef logic [3:0] regaddr_t;

endpackage

// File: rtl/decoder_4to16.sv
// 4-bit address to 16-bit one-hot decoder; all-zero output when not enabled.
module decoder_4to16
   import cpu_pkg::*;
(
   input  regaddr_t    addr,
   input  logic        en,
   output logic [15:0] onehot
);

   generate
      for (genvar gi = 0; gi < 16; gi++) begin : g_dec
         assign onehot[gi] = en && (addr == regaddr_t'(gi));
      end
   endgenerate

endmodule

// File: rtl/select_encode_regfile.sv
// Instruction register, select/encode logic and R0..R15 register file that
// feed the external bus multiplexer.
module select_encode_regfile
   import cpu_pkg::*;
#(
   parameter int NREGS  = NREGS_DEF,
   parameter int CWIDTH = CWIDTH_DEF
) (
   input  logic        clock,
   input  logic        clear,
   input  logic [31:0] BusMuxOut,
   input  logic        IRin,
   input  logic        Gra,
   input  logic        Grb,
   input  logic        Grc,
   input  logic        Rin,
   input  logic        Rout,
   input  logic        BAout,
   output logic [31:0] IR,
   output logic        R0out,
   output logic        R1out,
   output logic        R2out,
   output logic        R3out,
   output logic        R4out,
   output logic        R5out,
   output logic        R6out,
   output logic        R7out,
   output logic        R8out,
   output logic        R9out,
   output logic        R10out,
   output logic        R11out,
   output logic        R12out,
   output logic        R13out,
   output logic        R14out,
   output logic        R15out,
   output logic [31:0] BusMuxInR0,
   output logic [31:0] BusMuxInR1,
   output logic [31:0] BusMuxInR2,
   output logic [31:0] BusMuxInR3,
   output logic [31:0] BusMuxInR4,
   output logic [31:0] BusMuxInR5,
   output logic [31:0] BusMuxInR6,
   output logic [31:0] BusMuxInR7,
   output logic [31:0] BusMuxInR8,
   output logic [31:0] BusMuxInR9,
   output logic [31:0] BusMuxInR10,
   output logic [31:0] BusMuxInR11,
   output logic [31:0] BusMuxInR12,
   output logic [31:0] BusMuxInR13,
   output logic [31:0] BusMuxInR14,
   output logic [31:0] BusMuxInR15,
   output logic [31:0] BusMuxInCsignextended
);

   logic [31:0] ir_reg;
   logic [31:0] regs_reg [NREGS];
   regaddr_t    sel_addr;
   logic        sel_en;
   logic [15:0] dsel;
   logic [15:0] strobe;

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         ir_reg <= '0;
      end else if (IRin) begin
         ir_reg <= BusMuxOut;
      end
   end

   // Address is decoded from the pre-edge IR, so IRin+Rin together write
   // the register named by the old instruction.
   always_comb begin
      sel_en   = 1'b1;
      sel_addr = '0;
      if (Gra)      sel_addr = ir_reg[RA_MSB:RA_LSB];
      else if (Grb) sel_addr = ir_reg[RB_MSB:RB_LSB];
      else if (Grc) sel_addr = ir_reg[RC_MSB:RC_LSB];
      else          sel_en   = 1'b0;
   end

   decoder_4to16 u_dec (
      .addr   (sel_addr),
      .en     (sel_en),
      .onehot (dsel)
   );

   assign strobe = dsel & {16{Rout | BAout}};

   generate
      for (genvar gi = 0; gi < NREGS; gi++) begin : g_regs
         always_ff @(posedge clock or negedge clear) begin
            if (!clear) begin
               regs_reg[gi] <= '0;
            end else if (dsel[gi] && Rin) begin
               regs_reg[gi] <= BusMuxOut;
            end
         end
      end
   endgenerate

   assign IR = ir_reg;
   assign BusMuxInCsignextended = {{(32-CWIDTH){ir_reg[CWIDTH-1]}}, ir_reg[CWIDTH-1:0]};

   assign {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
           R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out} = strobe;

   // Base-address reads treat R0 as the constant zero.
   assign BusMuxInR0  = BAout ? 32'h0 : regs_reg[0];
   assign BusMuxInR1  = regs_reg[1];
   assign BusMuxInR2  = regs_reg[2];
   assign BusMuxInR3  = regs_reg[3];
   assign BusMuxInR4  = regs_reg[4];
   assign BusMuxInR5  = regs_reg[5];
   assign BusMuxInR6  = regs_reg[6];
   assign BusMuxInR7  = regs_reg[7];
   assign BusMuxInR8  = regs_reg[8];
   assign BusMuxInR9  = regs_reg[9];
   assign BusMuxInR10 = regs_reg[10];
   assign BusMuxInR11 = regs_reg[11];
   assign BusMuxInR12 = regs_reg[12];
   assign BusMuxInR13 = regs_reg[13];
   assign BusMuxInR14 = regs_reg[14];
   assign BusMuxInR15 = regs_reg[15];

endmodule

// File: tb/tb_select_encode_regfile.sv
// Directed bench for select_encode_regfile with hand-computed expectations.
module tb_select_encode_regfile;

   logic        clock = 1'b0;
   logic        clear;
   logic [31:0] BusMuxOut;
   logic        IRin, Gra, Grb, Grc, Rin, Rout, BAout;
   logic [31:0] IR;
   logic [31:0] csx;
   logic [15:0] strobes;
   logic [31:0] bm [16];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   select_encode_regfile dut (
      .clock(clock), .clear(clear), .BusMuxOut(BusMuxOut),
      .IRin(IRin), .Gra(Gra), .Grb(Grb), .Grc(Grc),
      .Rin(Rin), .Rout(Rout), .BAout(BAout), .IR(IR),
      .R0out(strobes[0]),   .R1out(strobes[1]),   .R2out(strobes[2]),   .R3out(strobes[3]),
      .R4out(strobes[4]),   .R5out(strobes[5]),   .R6out(strobes[6]),   .R7out(strobes[7]),
      .R8out(strobes[8]),   .R9out(strobes[9]),   .R10out(strobes[10]), .R11out(strobes[11]),
      .R12out(strobes[12]), .R13out(strobes[13]), .R14out(strobes[14]), .R15out(strobes[15]),
      .BusMuxInR0(bm[0]),   .BusMuxInR1(bm[1]),   .BusMuxInR2(bm[2]),   .BusMuxInR3(bm[3]),
      .BusMuxInR4(bm[4]),   .BusMuxInR5(bm[5]),   .BusMuxInR6(bm[6]),   .BusMuxInR7(bm[7]),
      .BusMuxInR8(bm[8]),   .BusMuxInR9(bm[9]),   .BusMuxInR10(bm[10]), .BusMuxInR11(bm[11]),
      .BusMuxInR12(bm[12]), .BusMuxInR13(bm[13]), .BusMuxInR14(bm[14]), .BusMuxInR15(bm[15]),
      .BusMuxInCsignextended(csx)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic idle();
      IRin = 0; Gra = 0; Grb = 0; Grc = 0; Rin = 0; Rout = 0; BAout = 0;
   endtask

   // One rising edge, then settle; inputs are changed only after this.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic load_ir(input logic [31:0] v);
      idle(); BusMuxOut = v; IRin = 1;
      tick();
      idle();
   endtask

   task automatic write_ra(input logic [31:0] v);
      idle(); BusMuxOut = v; Gra = 1; Rin = 1;
      tick();
      idle();
   endtask

   initial begin
      idle();
      BusMuxOut = '0;
      clear = 0;
      #12;
      check("rst_ir", IR, 32'h0);
      check("rst_r5", bm[5], 32'h0);
      check("rst_csx", csx, 32'h0);
      Gra = 1; Rout = 1; #1;
      check("rst_strobe_r0", {16'h0, strobes}, 32'h0001);
      idle(); #1;
      check("rst_strobe_none", {16'h0, strobes}, 32'h0);
      @(negedge clock); clear = 1;
      tick();

      load_ir(32'h0A980000);
      check("ir_load", IR, 32'h0A980000);

      // Rin and Rout together: old value until the edge
      idle(); BusMuxOut = 32'h22; Gra = 1; Rin = 1; Rout = 1; #1;
      check("r5_pre_edge", bm[5], 32'h0);
      check("r5_strobe", {16'h0, strobes}, 32'h0020);
      tick(); idle();
      check("r5_written", bm[5], 32'h22);
      check("r3_unchanged", bm[3], 32'h0);
      check("r0_unchanged", bm[0], 32'h0);

      Gra = 1; Grb = 1; Rout = 1; #1;
      check("prio_ab", {16'h0, strobes}, 32'h0020);
      idle(); Grb = 1; Rout = 1; #1;
      check("prio_b", {16'h0, strobes}, 32'h0008);
      idle(); Grb = 1; Grc = 1; Rout = 1; #1;
      check("prio_bc", {16'h0, strobes}, 32'h0008);
      idle(); Grc = 1; Rout = 1; #1;
      check("prio_c", {16'h0, strobes}, 32'h0001);
      idle(); Rout = 1; BAout = 1; #1;
      check("no_g", {16'h0, strobes}, 32'h0);
      idle(); Gra = 1; #1;
      check("no_out", {16'h0, strobes}, 32'h0);

      idle(); BusMuxOut = 32'hFFFF; Rin = 1;
      tick(); idle();
      check("rin_nog_r5", bm[5], 32'h22);
      check("rin_nog_r0", bm[0], 32'h0);
      check("rin_nog_r3", bm[3], 32'h0);

      // Asynchronous clear mid-cycle
      write_ra(32'hDEADBEEF);
      check("r5_beef", bm[5], 32'hDEADBEEF);
      @(negedge clock); #2;
      clear = 0; #1;
      check("aclr_r5", bm[5], 32'h0);
      check("aclr_ir", IR, 32'h0);
      // Pending write during clear is aborted
      BusMuxOut = 32'h0A980000; IRin = 1; Rin = 1; Gra = 1;
      tick();
      check("clr_abort_ir", IR, 32'h0);
      check("clr_abort_r0", bm[0], 32'h0);
      idle(); BusMuxOut = 32'h0A980000; IRin = 1;
      @(negedge clock); clear = 1;
      tick(); idle();
      check("first_after_clr", IR, 32'h0A980000);

      // BAout forces R0 to read zero
      load_ir(32'h0);
      write_ra(32'h1234);
      Gra = 1; BAout = 1; #1;
      check("ba_strobe", {16'h0, strobes}, 32'h0001);
      check("ba_r0_zero", bm[0], 32'h0);
      idle(); Gra = 1; Rout = 1; #1;
      check("rout_r0", bm[0], 32'h1234);
      idle();

      // IRin+Rin in the same cycle uses the old Ra
      load_ir(32'h01000000);
      idle(); BusMuxOut = 32'h03800055; IRin = 1; Gra = 1; Rin = 1;
      tick(); idle();
      check("same_r2", bm[2], 32'h03800055);
      check("same_r7", bm[7], 32'h0);
      check("same_ir", IR, 32'h03800055);
      Gra = 1; Rout = 1; #1;
      check("same_strobe_r7", {16'h0, strobes}, 32'h0080);
      idle();

      load_ir(32'h0007FFFF);
      check("sext_neg", csx, 32'hFFFFFFFF);
      load_ir(32'h0003FFFF);
      check("sext_pos", csx, 32'h0003FFFF);
      load_ir(32'hFFF40000);
      check("sext_hi", csx, 32'hFFFC0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
